// File: rtl/count_dir_decoder.sv
// ---------------------------------------------------------------------------
// count_dir_decoder
//
// Purpose:
//   Receive-side monitor for a binary up/down count stream. It compares each
//   accepted sample with the previous one and classifies the step as UP,
//   DOWN, HOLD or ERR. From the steps it recovers the direction input that
//   drove the counter. The direction is reported as valid only after
//   LOCK_COUNT consecutive steps in the same direction. Illegal steps raise a
//   one-cycle pulse and bump a saturating error counter.
//
// Optional feature:
//   Define COUNT_DIR_DEC_WRAP_EN to add the `wrap` output. It pulses for one
//   cycle on an accepted UP step from all-ones to zero, or on a DOWN step
//   from zero to all-ones.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   q_in       in   observed count value (WIDTH bits)
//   q_valid    in   q_in is sampled on this clock edge
//   dir        out  recovered direction (1 = up, 0 = down)
//   dir_valid  out  dir is locked and trustworthy
//   step_err   out  one-cycle pulse: last accepted sample was an illegal step
//   wrap       out  one-cycle pulse on a wrap-around step (optional)
//   err_count  out  saturating count of illegal steps (ERR_W bits)
// ---------------------------------------------------------------------------
module count_dir_decoder #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 2,   // legal range 1..15
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_valid,
    output logic             dir,
    output logic             dir_valid,
    output logic             step_err,
`ifdef COUNT_DIR_DEC_WRAP_EN
    output logic             wrap,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ACQ   = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [1:0] STEP_HOLD = 2'd0;
    localparam logic [1:0] STEP_UP   = 2'd1;
    localparam logic [1:0] STEP_DOWN = 2'd2;
    localparam logic [1:0] STEP_ERR  = 2'd3;

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] prev_q,      prev_d;
    logic [3:0]       streak_q,    streak_d;
    logic             cand_q,      cand_d;
    logic             dir_q,       dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic             step_err_q,  step_err_d;
    logic [ERR_W-1:0] err_q,       err_d;

    logic [WIDTH-1:0] delta;
    logic [1:0]       step;
    logic             step_up;

    // Modular difference: wrap-around steps (max->0, 0->max) come out as
    // +1 / -1 without any special casing.
    always_comb begin
        delta = q_in - prev_q;
        if (delta == '0) begin
            step = STEP_HOLD;
        end else if (delta == ONE) begin
            step = STEP_UP;
        end else if (delta == '1) begin
            step = STEP_DOWN;
        end else begin
            step = STEP_ERR;
        end
    end

    assign step_up = (step == STEP_UP);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        prev_d      = prev_q;
        streak_d    = streak_q;
        cand_d      = cand_q;
        dir_d       = dir_q;
        dir_valid_d = dir_valid_q;
        step_err_d  = 1'b0;
        err_d       = err_q;

        if (q_valid) begin
            prev_d = q_in;
            case (state_q)
                ST_EMPTY: begin
                    // First sample only seeds prev; there is nothing to compare.
                    state_d  = ST_ACQ;
                    streak_d = '0;
                end
                ST_ACQ, ST_LOCK: begin
                    if (step == STEP_ERR) begin
                        step_err_d  = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        dir_valid_d = 1'b0;
                        streak_d    = '0;
                        state_d     = ST_ACQ;
                    end else if (step != STEP_HOLD) begin
                        if (state_q == ST_ACQ) begin
                            // streak==0 means no candidate yet.
                            if (streak_q != '0 && cand_q == step_up) begin
                                streak_d = streak_q + 4'd1;
                            end else begin
                                cand_d   = step_up;
                                streak_d = 4'd1;
                            end
                            if (streak_d == LOCK_N) begin
                                state_d     = ST_LOCK;
                                dir_d       = cand_d;
                                dir_valid_d = 1'b1;
                            end
                        end else if (step_up != dir_q) begin
                            cand_d   = step_up;
                            streak_d = 4'd1;
                            if (LOCK_N == 4'd1) begin
                                // A single step is already a full lock.
                                dir_d = step_up;
                            end else begin
                                dir_valid_d = 1'b0;
                                state_d     = ST_ACQ;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            prev_q      <= '0;
            streak_q    <= '0;
            cand_q      <= 1'b0;
            dir_q       <= 1'b0;
            dir_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other, independent of statement order.
            state_q     <= state_d;
            prev_q      <= prev_d;
            streak_q    <= streak_d;
            cand_q      <= cand_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            step_err_q  <= step_err_d;
            err_q       <= err_d;
        end
    end

    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;
    assign step_err  = step_err_q;
    assign err_count = err_q;

`ifdef COUNT_DIR_DEC_WRAP_EN
    logic wrap_q, wrap_d;

    always_comb begin
        wrap_d = 1'b0;
        if (q_valid && state_q != ST_EMPTY) begin
            wrap_d = (step == STEP_UP   && prev_q == '1) ||
                     (step == STEP_DOWN && prev_q == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_count_dir_decoder.sv
// ---------------------------------------------------------------------------
// tb_count_dir_decoder
//
// Self-checking bench for count_dir_decoder. A small behavioural model runs
// alongside the stimulus; each driven cycle pushes the model's expected
// outputs to a scoreboard queue, which is popped and compared one edge
// later. Directed checks with literal values cover the key scenarios.
// Build with COUNT_DIR_DEC_WRAP_EN to also cover the wrap output.
// ---------------------------------------------------------------------------
module tb_count_dir_decoder;

    localparam int WIDTH      = 3;
    localparam int LOCK_COUNT = 2;
    localparam int ERR_W      = 8;
    localparam int M          = 1 << WIDTH;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    localparam int S_EMPTY = 0;
    localparam int S_ACQ   = 1;
    localparam int S_LOCK  = 2;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] q_in;
    logic             q_valid;
    logic             dir;
    logic             dir_valid;
    logic             step_err;
    logic [ERR_W-1:0] err_count;
`ifdef COUNT_DIR_DEC_WRAP_EN
    logic             wrap;
`endif

    count_dir_decoder #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .q_in      (q_in),
        .q_valid   (q_valid),
        .dir       (dir),
        .dir_valid (dir_valid),
        .step_err  (step_err),
`ifdef COUNT_DIR_DEC_WRAP_EN
        .wrap      (wrap),
`endif
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dir;
        int dv;
        int serr;
        int wrap;
        int errc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_state, m_prev, m_streak, m_cand, m_dir, m_dv, m_err, m_serr, m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = S_EMPTY;
        m_prev   = 0;
        m_streak = 0;
        m_cand   = 0;
        m_dir    = 0;
        m_dv     = 0;
        m_err    = 0;
        m_serr   = 0;
        m_wrap   = 0;
    endtask

    task automatic model_step(input bit v, input int q);
        int   d;
        int   s;
        exp_t e;
        m_serr = 0;
        m_wrap = 0;
        if (v) begin
            if (m_state == S_EMPTY) begin
                m_state  = S_ACQ;
                m_streak = 0;
            end else begin
                d = (q - m_prev + M) % M;
                if (d == 1 || d == M - 1) begin
                    s = (d == 1) ? 1 : 0;
                    m_wrap = ((d == 1) && (m_prev == M - 1)) || ((d == M - 1) && (m_prev == 0));
                    if (m_state == S_LOCK) begin
                        if (s != m_dir) begin
                            m_cand   = s;
                            m_streak = 1;
                            if (LOCK_COUNT == 1) begin
                                m_dir = s;
                            end else begin
                                m_dv    = 0;
                                m_state = S_ACQ;
                            end
                        end
                    end else begin
                        if (m_streak > 0 && m_cand == s) m_streak++;
                        else begin
                            m_cand   = s;
                            m_streak = 1;
                        end
                        if (m_streak >= LOCK_COUNT) begin
                            m_state = S_LOCK;
                            m_dir   = s;
                            m_dv    = 1;
                        end
                    end
                end else if (d != 0) begin
                    m_serr = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_dv     = 0;
                    m_streak = 0;
                    m_state  = S_ACQ;
                end
            end
            m_prev = q;
        end
        e.dir  = m_dir;
        e.dv   = m_dv;
        e.serr = m_serr;
        e.wrap = m_wrap;
        e.errc = m_err;
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        check("sb_has_entry", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_dir",       dir,       e.dir);
            check("sb_dir_valid", dir_valid, e.dv);
            check("sb_step_err",  step_err,  e.serr);
            check("sb_err_count", err_count, e.errc);
`ifdef COUNT_DIR_DEC_WRAP_EN
            check("sb_wrap",      wrap,      e.wrap);
`endif
        end
    endtask

    // Drive one cycle between edges, predict, then compare 1 time unit
    // after the sampling edge.
    task automatic drive(input bit v, input int q);
        @(negedge clk);
        q_valid = v;
        q_in    = WIDTH'(q);
        model_step(v, q);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_dir",       dir,       0);
        check("rst_dir_valid", dir_valid, 0);
        check("rst_step_err",  step_err,  0);
        check("rst_err_count", err_count, 0);
`ifdef COUNT_DIR_DEC_WRAP_EN
        check("rst_wrap",      wrap,      0);
`endif
        @(negedge clk);
        q_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        int q;
        reset_n = 1'b0;
        q_valid = 1'b0;
        q_in    = '0;
        model_reset();
        #1;
        check("por_dir_valid", dir_valid, 0);
        check("por_err_count", err_count, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Count up 0,1,2,3: lock one clock after sample 2.
        drive(1, 0);
        drive(1, 1);
        check("up_no_lock_yet", dir_valid, 0);
        drive(1, 2);
        check("up_locked_dv",  dir_valid, 1);
        check("up_locked_dir", dir,       1);
        drive(1, 3);
        check("up_no_err", err_count, 0);

        // Locked down 5,4,3 then 2,1,0,7 across the wrap.
        do_reset();
        drive(1, 5);
        drive(1, 4);
        drive(1, 3);
        check("down_locked_dv",  dir_valid, 1);
        check("down_locked_dir", dir,       0);
        drive(1, 2);
        drive(1, 1);
        drive(1, 0);
        drive(1, 7);
        check("down_wrap_dir",  dir,       0);
        check("down_wrap_dv",   dir_valid, 1);
        check("down_wrap_nerr", step_err,  0);
`ifdef COUNT_DIR_DEC_WRAP_EN
        check("down_wrap_pulse", wrap, 1);
`endif
        drive(1, 7);
`ifdef COUNT_DIR_DEC_WRAP_EN
        check("down_wrap_gone", wrap, 0);
`endif

        // Illegal jump 2->4 while locked up, then relock on 5,6.
        do_reset();
        drive(1, 0);
        drive(1, 1);
        drive(1, 2);
        drive(1, 4);
        check("err_pulse",   step_err,  1);
        check("err_count1",  err_count, 1);
        check("err_dv_drop", dir_valid, 0);
        drive(1, 5);
        check("err_pulse_one_cycle", step_err, 0);
        drive(1, 6);
        check("relock_dv",  dir_valid, 1);
        check("relock_dir", dir,       1);

        // HOLD and idle gaps keep lock; reversal drops then relocks down.
        do_reset();
        drive(1, 0);
        drive(1, 1);
        drive(1, 2);
        drive(1, 3);
        drive(1, 3);
        drive(0, 5);
        drive(1, 3);
        drive(0, 0);
        check("hold_dv_kept", dir_valid, 1);
        check("hold_no_err",  err_count, 0);
        drive(1, 2);
        check("rev_dv_drop", dir_valid, 0);
        drive(1, 1);
        check("rev_relock_dv",  dir_valid, 1);
        check("rev_relock_dir", dir,       0);

        // 300 accepted samples alternating 0,4: error counter saturates.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, (i % 2 == 0) ? 0 : 4);
        end
        check("sat_err_count", err_count, ERR_MAX);
        check("sat_still_pulses", step_err, 1);

        // Mid-operation reset while locked; first samples afterwards.
        do_reset();
        drive(1, 0);
        drive(1, 1);
        drive(1, 2);
        check("pre_reset_locked", dir_valid, 1);
        do_reset();
        drive(1, 6);
        check("post_rst_first_nerr", step_err,  0);
        check("post_rst_first_dv",   dir_valid, 0);
        drive(1, 7);
        check("post_rst_second_dv",  dir_valid, 0);
`ifdef COUNT_DIR_DEC_WRAP_EN
        drive(1, 0);
        check("up_wrap_pulse", wrap, 1);
`endif

        // Mixed random traffic checked against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      q = (m_prev + 1) % M;
            else if (r <= 6) q = (m_prev + M - 1) % M;
            else if (r == 7) q = m_prev;
            else             q = $urandom_range(0, M - 1);
            drive((r != 9), q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
